select_multi_pipe: RTL

Parametrised, registered N:1 word selector with valid/ready flow control, the pipelined successor of the CPU datapath's combinational 4:1 select. It picks one of NUM_IN WIDTH-bit channels by `sel`, registers the result with its select and an out-of-range flag, and holds it until the consumer accepts it. It sits between operand-source stages and execute/writeback wherever a select path must be cut by a register without losing back-pressure.

---
 rtl/select_multi_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/select_multi_pipe.sv
// select_multi_pipe: registered NUM_IN:1 word selector with valid/ready back-pressure.
// Define SELECT_MULTI_SKID_EN to add a one-entry skid register and register in_ready.
module select_multi_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [WIDTH-1:0] pick_data, src_data, out_data_q, out_data_d;
  logic [SEL_W-1:0] src_sel, out_sel_q, out_sel_d;
  logic             pick_err, src_err, out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_fire, out_fire, load_out;

  // Out-of-range selects match no channel, so the word is forced to zero.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) pick_data = in_data[k*WIDTH +: WIDTH];
  end

  assign pick_err = 32'(sel) >= 32'(NUM_IN);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

`ifdef SELECT_MULTI_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d, skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d, load_skid;

  // A held skid word always drains before any newer input can reach the output.
  always_comb begin
    load_skid    = in_fire && out_valid_q && !out_ready;
    load_out     = skid_valid_q ? out_fire : in_fire && !load_skid;
    src_data     = skid_valid_q ? skid_data_q : pick_data;
    src_sel      = skid_valid_q ? skid_sel_q : sel;
    src_err      = skid_valid_q ? skid_err_q : pick_err;
    skid_data_d  = load_skid ? pick_data : skid_data_q;
    skid_sel_d   = load_skid ? sel : skid_sel_q;
    skid_err_d   = load_skid ? pick_err : skid_err_q;
    skid_valid_d = load_skid || (skid_valid_q && !out_fire);
    in_ready_d   = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid_q || out_ready;
  assign load_out = in_fire;
  assign src_data = pick_data;
  assign src_sel  = sel;
  assign src_err  = pick_err;
`endif

  always_comb begin
    out_data_d  = load_out ? src_data : out_data_q;
    out_sel_d   = load_out ? src_sel : out_sel_q;
    out_err_d   = load_out ? src_err : out_err_q;
    out_valid_d = load_out || (out_valid_q && !out_fire);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
endmodule
